// File: rtl/apu_mixer_pwm.sv
// Time-multiplexed weighted mixer for NUM_CH audio channels driving a 1-bit DAC
// that is either a glitch-free PWM or a first-order sigma-delta modulator.
module apu_mixer_pwm #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 4,
  parameter int VOL_W    = 4,
  parameter int VOL_INIT = 2**VOL_W-1,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MIX_W    = SAMPLE_W + VOL_W + $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       mode,
  input  logic                       cfg_valid,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [VOL_W-1:0]           cfg_vol,
  output logic                       cfg_ready,
  output logic                       cfg_err,
  output logic [MIX_W-1:0]           mix_value,
  output logic                       mix_valid,
  output logic                       pwm
);

  localparam int PROD_W = SAMPLE_W + VOL_W;

  localparam logic [1:0] ST_SNAP = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [VOL_W-1:0] VOL_RST  = VOL_W'(VOL_INIT);
  localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(NUM_CH - 1);

  logic [1:0]          state;
  logic [CH_W-1:0]     idx;
  logic [MIX_W-1:0]    acc;
  logic [SAMPLE_W-1:0] snap_samp [NUM_CH];
  logic [NUM_CH-1:0]   snap_en;
  logic [VOL_W-1:0]    vol_shadow [NUM_CH];
  logic [VOL_W-1:0]    vol_act [NUM_CH];

  logic [SAMPLE_W-1:0] cur_samp;
  logic [VOL_W-1:0]    cur_vol;
  logic                cur_en;
  logic [PROD_W-1:0]   prod;

  logic                cfg_fire;
  logic                cfg_bad;

  logic [MIX_W-1:0]    pwm_cnt;
  logic [MIX_W-1:0]    duty;
  logic                mode_q;
  logic [MIX_W:0]      sd_acc;
  logic [MIX_W:0]      sd_next;
  logic                wrap;

  // Config handshake: a write transfers on any cycle with cfg_valid & cfg_ready.
  // cfg_ready is held high whenever out of reset, so the port never back-pressures.
  assign cfg_fire = cfg_valid & cfg_ready;
  assign cfg_bad  = {1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) vol_shadow[i] <= VOL_RST;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= cfg_fire & cfg_bad;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_fire && cfg_ch == CH_W'(i)) vol_shadow[i] <= cfg_vol;
      end
    end
  end

  always_comb begin
    cur_samp = '0;
    cur_vol  = '0;
    cur_en   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == CH_W'(i)) begin
        cur_samp = snap_samp[i];
        cur_vol  = vol_act[i];
        cur_en   = snap_en[i];
      end
    end
    prod = cur_en ? (PROD_W'(cur_samp) * PROD_W'(cur_vol)) : '0;
  end

  // Volumes are copied from the shadow set only in SNAP, so a frame always
  // mixes with one consistent volume set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SNAP;
      idx       <= '0;
      acc       <= '0;
      mix_value <= '0;
      mix_valid <= 1'b0;
      snap_en   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_samp[i] <= '0;
        vol_act[i]   <= VOL_RST;
      end
    end else begin
      mix_valid <= 1'b0;
      case (state)
        ST_SNAP: begin
          for (int i = 0; i < NUM_CH; i++) begin
            snap_samp[i] <= ch_sample[i*SAMPLE_W +: SAMPLE_W];
            vol_act[i]   <= vol_shadow[i];
          end
          snap_en <= ch_enable;
          acc     <= '0;
          idx     <= '0;
          state   <= ST_ACC;
        end
        ST_ACC: begin
          acc <= acc + MIX_W'(prod);
          if (idx == LAST_IDX) state <= ST_DONE;
          else                 idx   <= idx + CH_W'(1);
        end
        ST_DONE: begin
          mix_value <= acc;
          mix_valid <= 1'b1;
          state     <= ST_SNAP;
        end
        default: state <= ST_SNAP;
      endcase
    end
  end

  // Duty and mode are only reloaded on the counter wrap, so every output period
  // is generated entirely from one duty/mode pair.
  assign wrap    = &pwm_cnt;
  assign sd_next = {1'b0, sd_acc[MIX_W-1:0]} + {1'b0, duty};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty    <= '0;
      mode_q  <= 1'b0;
      sd_acc  <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + MIX_W'(1);
      if (wrap) begin
        duty   <= mix_value;
        mode_q <= mode;
      end
      if (mode_q) begin
        sd_acc <= sd_next;
        pwm    <= sd_next[MIX_W];
      end else begin
        pwm <= (pwm_cnt < duty);
      end
    end
  end

endmodule

// File: doc/apu_mixer_pwm.md
Name: apu_mixer_pwm

Overview:
Parametrised N-channel audio mixer and 1-bit DAC driver for the APU. It replaces the fixed four-channel merge with a time-multiplexed weighted sum, using per-channel volume registers written over a valid/ready config port. The mixed word drives either a glitch-free PWM or a first-order sigma-delta output. The block sits between the channel generators and the external low-pass filter pin.

Parameters:
NUM_CH, 4, number of audio channels (>=1)
SAMPLE_W, 4, bits per channel sample (unsigned)
VOL_W, 4, bits per volume register (unsigned)
VOL_INIT, 2**VOL_W-1, reset value of every volume register
CH_W, max(1,$clog2(NUM_CH)), width of cfg_ch (derived)
MIX_W, SAMPLE_W+VOL_W+$clog2(NUM_CH), mix word width (derived; sized so the sum cannot overflow)

Ports:
clk  in  1  system clock (1.789773 MHz nominal)
rst_n  in  1  synchronous active-low reset
ch_sample  in  NUM_CH*SAMPLE_W  packed samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
ch_enable  in  NUM_CH  per-channel enable; 0 contributes zero
mode  in  1  0 = PWM, 1 = sigma-delta
cfg_valid  in  1  volume write request
cfg_ch  in  CH_W  target channel index
cfg_vol  in  VOL_W  volume value
cfg_ready  out  1  write accept
cfg_err  out  1  one-cycle pulse on an accepted write with cfg_ch >= NUM_CH
mix_value  out  MIX_W  last completed mix
mix_valid  out  1  one-cycle pulse when mix_value updates
pwm  out  1  1-bit DAC output

Behaviour:
- Reset is synchronous on the clk edge with rst_n=0. During reset: state=SNAP, accumulators/counters=0, mix_value=0, mix_valid=0, pwm=0, cfg_err=0, cfg_ready=0, all volume and shadow volume registers=VOL_INIT.
- cfg_ready=1 in every cycle after reset is released.
- Config handshake: a write is accepted on a cycle with cfg_valid & cfg_ready.
  - Valid index: write the shadow volume register for cfg_ch.
  - Index >= NUM_CH: no register changes; cfg_err=1 in the next cycle.
  - Back-to-back writes are accepted every cycle. The last write to a given index before the copy point wins.
- Scan FSM, frame length NUM_CH+2 cycles, free-running:
  - SNAP (1 cycle): latch all ch_sample & ch_enable into a snapshot; copy shadow volumes into active volumes; clear acc.
  - ACC (NUM_CH cycles, idx 0..NUM_CH-1): acc += en[idx] ? samp[idx]*vol[idx] : 0. The product is SAMPLE_W+VOL_W bits, zero-extended to MIX_W.
  - DONE (1 cycle): mix_value <= acc; mix_valid=1 in the following cycle; next state SNAP.
- Latency: inputs sampled in the SNAP cycle t appear on mix_value at cycle t+NUM_CH+2.
- A shadow write accepted in the same cycle as SNAP misses that copy and applies at the next frame.
- Input changes outside SNAP have no effect on the frame in progress.
- DAC stage:
  - Free-running pwm_cnt of MIX_W bits, wrapping 2^MIX_W-1 -> 0.
  - On the wrap cycle (pwm_cnt == all ones), duty <= mix_value and mode_q <= mode.
  - mode_q=0: pwm registered as (pwm_cnt < duty). Duty 0 gives constant 0; duty d gives d high cycles per 2^MIX_W-cycle period.
  - mode_q=1: sd_acc (MIX_W+1 bits) <= sd_acc[MIX_W-1:0] + duty; pwm registered as sd_acc carry bit.
  - A mode or duty change never produces a partial PWM period.
- Reset asserted mid-frame or mid-period aborts everything to the reset values above. Volumes return to VOL_INIT.

Test Plan:
- Defaults NUM_CH=4, S=4, V=4 (MIX_W=10), no cfg writes, all samples 15, all enabled -> mix_value=900 (4*15*15), first mix_valid 6 cycles after the first SNAP; PWM period 1024 with exactly 900 high cycles.
- Mask and weight: ch_enable=0b0101, samples {1,2,3,4} (ch0..3), cfg writes vol[0]=2, vol[2]=5 -> after the next full frame mix_value=1*2+3*5=17.
- Config boundary: NUM_CH=3 (CH_W=2), cfg_ch=3 with cfg_valid -> cfg_err pulses once and the following mix is unchanged. A write landing in the SNAP cycle takes effect one frame later.
- Glitch-free update: change mix from 100 to 600 mid-period -> the current period has 100 high cycles and the next period has 600. Duty 0 -> pwm held at 0; duty 1023 -> 1023 high per 1024.
- Sigma-delta: mode=1, mix_value=256 -> after the wrap, pwm is high on exactly 1 cycle in every 4 (256 high per 1024 cycles), with no two consecutive highs.
- Reset mid-operation: assert rst_n=0 for 1 cycle during ACC after setting vol[1]=3 -> mix_value=0, pwm=0, mix_valid=0; vol[1] is back to 15; a frame restarts from SNAP.
